// File: rtl/bitmask_visit_ctrl.sv
// Visited-bitmap RAM sequencer: round-robin test-and-set for two BFS lanes plus full clear sweep.
// Optional VISIT_COUNT_EN adds visit_count, the number of newly visited vertices since the last clear.
module bitmask_visit_ctrl #(
    parameter int  ADDR_WIDTH   = 10,
    parameter int  DATA_WIDTH   = 32,
    localparam int BIT_SEL      = $clog2(DATA_WIDTH),
    localparam int VERTEX_WIDTH = ADDR_WIDTH + BIT_SEL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_start,
    output logic                    clear_busy,
    output logic                    clear_done,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [VERTEX_WIDTH-1:0] req0_vertex,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [VERTEX_WIDTH-1:0] req1_vertex,
    output logic                    rsp_valid,
    output logic                    rsp_id,
    output logic [VERTEX_WIDTH-1:0] rsp_vertex,
    output logic                    rsp_was_set,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout
`ifdef VISIT_COUNT_EN
    ,
    output logic [VERTEX_WIDTH:0]   visit_count
`endif
);

    typedef enum logic [1:0] {IDLE, CLEAR, RMW} state_t;

    typedef struct packed {
        logic                    id;
        logic [VERTEX_WIDTH-1:0] vertex;
    } req_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         clr_cnt_q;
    req_t                          cur_q;
    logic                          last_q;
    logic [1:0]                    req_valid;
    logic [1:0][VERTEX_WIDTH-1:0]  req_vtx;
    logic                          gnt_lane, gnt_any;
    logic [ADDR_WIDTH-1:0]         rmw_word;
    logic [BIT_SEL-1:0]            rmw_bit;
    logic [DATA_WIDTH-1:0]         mask;
    logic                          was;

    assign req_valid = {req1_valid, req0_valid};
    assign req_vtx   = {req1_vertex, req0_vertex};

    // Contention goes to the lane not granted last; a lone requester always wins.
    assign gnt_lane   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    assign gnt_any    = (state_q == IDLE) && !clear_start && (|req_valid);
    assign req0_ready = gnt_any && !gnt_lane;
    assign req1_ready = gnt_any && gnt_lane;

    assign rmw_word   = cur_q.vertex[VERTEX_WIDTH-1:BIT_SEL];
    assign rmw_bit    = cur_q.vertex[BIT_SEL-1:0];
    assign mask       = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << rmw_bit;
    assign was        = mem_dout[rmw_bit];
    assign clear_busy = (state_q == CLEAR);

    always_comb begin
        state_d  = state_q;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (state_q)
            IDLE: begin
                if (clear_start)  state_d = CLEAR;
                else if (gnt_any) state_d = RMW;
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_cnt_q;
                if (&clr_cnt_q) state_d = IDLE;
            end
            RMW: begin
                // Already-visited bits skip the write so the word is left untouched.
                mem_addr = rmw_word;
                mem_din  = mem_dout | mask;
                mem_we   = ~was;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            cur_q       <= '0;
            last_q      <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_vertex  <= '0;
            rsp_was_set <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_valid  <= (state_q == RMW);
            clear_done <= (state_q == CLEAR) && (&clr_cnt_q);
            if (state_q == IDLE && clear_start) clr_cnt_q <= '0;
            else if (state_q == CLEAR)          clr_cnt_q <= clr_cnt_q + 1'b1;
            if (gnt_any) begin
                cur_q  <= '{id: gnt_lane, vertex: req_vtx[gnt_lane]};
                last_q <= gnt_lane;
            end
            if (state_q == RMW) begin
                rsp_id      <= cur_q.id;
                rsp_vertex  <= cur_q.vertex;
                rsp_was_set <= was;
            end
        end
    end

`ifdef VISIT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                visit_count <= '0;
        else if (state_q == IDLE && clear_start)   visit_count <= '0;
        else if (state_q == RMW && !was)           visit_count <= visit_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_bitmask_visit_ctrl.sv
// Scoreboard bench for bitmask_visit_ctrl with a behavioural RAM and a reference bitmap.
// Build with VISIT_COUNT_EN defined to also exercise visit_count.
module tb_bitmask_visit_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BS = 5;
    localparam int VW = AW + BS;
    localparam int DEPTH = 1 << AW;

    logic          clk, rst_n, clear_start, clear_busy, clear_done;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [VW-1:0] req0_vertex, req1_vertex, rsp_vertex;
    logic          rsp_valid, rsp_id, rsp_was_set, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
`ifdef VISIT_COUNT_EN
    logic [VW:0]   visit_count;
`endif

    bitmask_visit_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_vertex(req0_vertex), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_vertex(req1_vertex), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_vertex(rsp_vertex), .rsp_was_set(rsp_was_set), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef VISIT_COUNT_EN
        , .visit_count(visit_count)
`endif
    );

    logic [DW-1:0] ram [0:DEPTH-1];
    assign mem_dout = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic          id;
        logic [VW-1:0] v;
        logic          was;
        int            cyc;
    } rsp_exp_t;
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        int            cyc;
    } wr_exp_t;

    rsp_exp_t      rq[$];
    wr_exp_t       wq[$];
    logic [DW-1:0] refmap [0:DEPTH-1];
    int            cyc = 0;
    int            exp_cnt = 0;
    logic          last_m = 1'b1;
    rsp_exp_t      e;
    wr_exp_t       w;
    logic          hs0, hs1, was_m;
    logic [VW-1:0] vm;
    logic [AW-1:0] wm;
    logic [BS-1:0] bm;

    // Monitor: predicts each accepted op from the reference bitmap, checks write and response.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_m = 1'b1;
            end else begin
                cyc++;
                if (rsp_valid) begin
                    if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
                    else begin
                        e = rq.pop_front();
                        chk("rsp", 64'({rsp_id, rsp_vertex, rsp_was_set}), 64'({e.id, e.v, e.was}));
                        chk("rsp_latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    w = wq.pop_front();
                    chk("rmw_write", 64'({mem_we, mem_addr, mem_din}), 64'({w.we, w.addr, w.din}));
                    chk("rdy_in_rmw", 64'({req1_ready, req0_ready}), 64'd0);
                end else if (mem_we && !clear_busy) chk("write_unexpected", 1, 0);
                if (clear_done) begin
                    for (int k = 0; k < DEPTH; k++) refmap[k] = '0;
                    exp_cnt = 0;
                end
                hs0 = req0_valid && req0_ready;
                hs1 = req1_valid && req1_ready;
                if (hs0 || hs1) begin
                    chk("one_grant", 64'(hs0 && hs1), 64'd0);
                    if (req0_valid && req1_valid) chk("rr_grant", 64'(hs1), 64'(!last_m));
                    last_m = hs1;
                    vm = hs1 ? req1_vertex : req0_vertex;
                    wm = vm[VW-1:BS];
                    bm = vm[BS-1:0];
                    was_m = refmap[wm][bm];
                    rq.push_back('{id: hs1, v: vm, was: was_m, cyc: cyc});
                    wq.push_back('{we: !was_m, addr: wm, din: refmap[wm] | (32'd1 << bm), cyc: cyc + 1});
                    refmap[wm][bm] = 1'b1;
                    if (!was_m) exp_cnt++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit u0, input logic [VW-1:0] v0, input bit u1, input logic [VW-1:0] v1);
        bit p0 = u0, p1 = u1, a0, a1;
        int n = 0;
        req0_vertex = v0; req1_vertex = v1;
        req0_valid = u0;  req1_valid = u1;
        while ((p0 || p1) && n < 50) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) begin req0_valid = 1'b0; p0 = 1'b0; end
            if (a1) begin req1_valid = 1'b0; p1 = 1'b0; end
            n++;
        end
        if (p0 || p1) begin
            chk("req_timeout", 1, 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
    endtask

    // Caller must be in IDLE; a pending req0 is accepted in the clear_done cycle and dropped here.
    task automatic do_clear();
        int bad = 0;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (!clear_busy || !mem_we || mem_addr != AW'(i) || mem_din != '0 || req0_ready || req1_ready)
                bad++;
        end
        chk("clear_sweep", 64'(bad), 64'd0);
        @(negedge clk);
        chk("clear_done", 64'({clear_done, clear_busy}), 64'b10);
        chk("rdy_after_clear", 64'(req0_ready), 64'(req0_valid));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("clear_done_pulse", 64'(clear_done), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int nz;
        rst_n = 1'b0; clear_start = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_vertex = '0; req1_vertex = '0;
        #12;
        chk("reset_outs", 64'({clear_busy, clear_done, rsp_valid, mem_we, mem_addr, mem_din, req0_ready, req1_ready}), 64'd0);
`ifdef VISIT_COUNT_EN
        chk("reset_vcnt", 64'(visit_count), 64'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        do_clear();
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] != '0) nz++;
        chk("ram_all_zero", 64'(nz), 64'd0);

        drive(0, '0, 1, 15'h0040);
        drive(1, 15'h0041, 0, '0);
        idle(3);
        chk("word2_after_40_41", 64'(ram[2]), 64'h3);

        drive(1, 15'h0045, 0, '0);
        idle(3);
        chk("word2_after_45", 64'(ram[2]), 64'h23);
        drive(1, 15'h0045, 0, '0);
        idle(3);

        drive(0, '0, 1, 15'h0400);
        drive(1, 15'h0010, 1, 15'h0020);
        drive(1, 15'h0030, 1, 15'h0050);
        idle(3);

        drive(1, 15'h0100, 0, '0);
        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        @(negedge clk);
        chk("clear_ignored_rmw", 64'(clear_busy), 64'd0);
        idle(3);

        req0_vertex = 15'h0123; req0_valid = 1'b1;
        do_clear();
        idle(3);

`ifdef VISIT_COUNT_EN
        do_clear();
        chk("vcnt_cleared", 64'(visit_count), 64'd0);
        drive(1, 15'h0001, 1, 15'h0202);
        drive(0, '0, 1, 15'h7fff);
        drive(1, 15'h0202, 0, '0);
        idle(3);
        chk("vcnt_three", 64'(visit_count), 64'd3);
        chk("vcnt_model", 64'(visit_count), 64'(exp_cnt));
        do_clear();
        chk("vcnt_zero", 64'(visit_count), 64'd0);
`endif

        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", 64'({clear_busy, clear_done, rsp_valid, mem_we, mem_addr, mem_din, req0_ready, req1_ready}), 64'd0);
`ifdef VISIT_COUNT_EN
        chk("rst_mid_vcnt", 64'(visit_count), 64'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        do_clear();
        drive(1, 15'h0045, 1, 15'h0045);
        idle(4);
        chk("scoreboard_drained", 64'(rq.size() + wq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
